// File: rtl/counter_mode_sequencer_pkg.sv
// Shared definitions for the counter display mode sequencer: mode encodings,
// one-hot segment masks and the INIT animation pattern lookup.
package counter_mode_sequencer_pkg;

  localparam int STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    STATE_INIT       = 3'd0,
    STATE_AUTO       = 3'd1,
    STATE_SWITCH     = 3'd2,
    STATE_BIT        = 3'd3,
    STATE_RESET_WAIT = 3'd4
  } state_t;

  // Segment bit order is {G,F,E,D,C,B,A}, active-high.
  localparam logic [6:0] SEGMENT_A = 7'b000_0001;
  localparam logic [6:0] SEGMENT_B = 7'b000_0010;
  localparam logic [6:0] SEGMENT_C = 7'b000_0100;
  localparam logic [6:0] SEGMENT_D = 7'b000_1000;
  localparam logic [6:0] SEGMENT_E = 7'b001_0000;
  localparam logic [6:0] SEGMENT_F = 7'b010_0000;
  localparam logic [6:0] SEGMENT_G = 7'b100_0000;

  localparam int ANIM_STEPS = 6;

  function automatic logic [6:0] anim_segments(input logic [2:0] step);
    case (step)
      3'd0:    anim_segments = SEGMENT_A;
      3'd1:    anim_segments = SEGMENT_B;
      3'd2:    anim_segments = SEGMENT_C;
      3'd3:    anim_segments = SEGMENT_D;
      3'd4:    anim_segments = SEGMENT_E;
      3'd5:    anim_segments = SEGMENT_F;
      default: anim_segments = SEGMENT_A;
    endcase
  endfunction

endpackage

// File: rtl/counter_mode_sequencer_chord_timer.sv
// Detects the SW1+SW4 control chord, keeps the chord_active mask flag and
// times how long the chord is held, producing short-release and hold pulses.
module chord_timer #(
  parameter int HOLD_TICKS = 50_000_000,
  parameter int TIMER_W    = 26
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic [3:0] i_Switches,
  output logic       o_Chord_Active,
  output logic       o_Short_Release,
  output logic       o_Hold_Done
);

  localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_TICKS - 1);

  logic               chord;
  logic               chord_q;
  logic               active_q;
  logic               fired_q;
  logic [TIMER_W-1:0] hold_cnt;

  assign chord = i_Switches[0] & i_Switches[3];

  // Active in the very cycle the chord forms, so the mask covers it immediately.
  assign o_Chord_Active = chord | active_q;

  // hold_cnt counts previously held cycles, so the threshold can coincide with
  // the release cycle; fired_q keeps the pulse single while the counter saturates.
  assign o_Hold_Done     = (hold_cnt == HOLD_LAST) & ~fired_q;
  assign o_Short_Release = chord_q & ~chord & ~fired_q;

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      chord_q  <= 1'b0;
      active_q <= 1'b0;
      fired_q  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      chord_q  <= chord;
      active_q <= (i_Switches == 4'b0000) ? 1'b0 : o_Chord_Active;
      fired_q  <= chord ? (fired_q | o_Hold_Done) : 1'b0;
      if (!chord) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_LAST) begin
        hold_cnt <= hold_cnt + TIMER_W'(1);
      end
    end
  end

endmodule

// File: rtl/counter_mode_sequencer.sv
// Mode controller for the 7-segment counter display: mode FSM, INIT animation
// stepper, counter reset generation and masked switch forwarding.
module counter_mode_sequencer
  import counter_mode_sequencer_pkg::*;
#(
  parameter int ANIM_TICKS = 2_500_000,
  parameter int HOLD_TICKS = 50_000_000
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic [3:0] i_Switches,
  output logic [2:0] o_State,
  output logic       o_Counter_Reset,
  output logic [6:0] o_Segments_Anim,
  output logic [3:0] o_Switches
);

  localparam int TIMER_W = $clog2((ANIM_TICKS > HOLD_TICKS) ? ANIM_TICKS : HOLD_TICKS);
  localparam logic [TIMER_W-1:0] ANIM_LAST = TIMER_W'(ANIM_TICKS - 1);
  localparam logic [2:0]         STEP_LAST = 3'(ANIM_STEPS - 1);

  state_t             state_q;
  state_t             state_d;
  logic [3:0]         sw_q;
  logic [3:0]         sw_out_q;
  logic               counter_reset_q;
  logic [TIMER_W-1:0] anim_cnt;
  logic [2:0]         anim_step;
  logic               chord_active;
  logic               short_release;
  logic               hold_done;
  logic               any_rise;

  chord_timer #(
    .HOLD_TICKS (HOLD_TICKS),
    .TIMER_W    (TIMER_W)
  ) u_chord_timer (
    .i_Clk           (i_Clk),
    .i_Reset_n       (i_Reset_n),
    .i_Switches      (i_Switches),
    .o_Chord_Active  (chord_active),
    .o_Short_Release (short_release),
    .o_Hold_Done     (hold_done)
  );

  assign any_rise = |(i_Switches & ~sw_q);

  // Hold threshold is tested before release everywhere, so it wins a tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STATE_AUTO: begin
        if (hold_done)          state_d = STATE_RESET_WAIT;
        else if (short_release) state_d = STATE_SWITCH;
      end
      STATE_SWITCH: begin
        if (hold_done)          state_d = STATE_RESET_WAIT;
        else if (short_release) state_d = STATE_BIT;
      end
      STATE_BIT: begin
        if (hold_done)          state_d = STATE_RESET_WAIT;
        else if (short_release) state_d = STATE_AUTO;
      end
      STATE_RESET_WAIT: begin
        if (i_Switches == 4'b0000) state_d = STATE_INIT;
      end
      default: begin
        if (hold_done)                                   state_d = STATE_RESET_WAIT;
        else if (short_release || (any_rise && !chord_active)) state_d = STATE_AUTO;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q         <= STATE_INIT;
      counter_reset_q <= 1'b1;
      sw_q            <= 4'b0000;
      sw_out_q        <= 4'b0000;
    end else begin
      state_q         <= state_d;
      counter_reset_q <= (state_d == STATE_INIT) || (state_d == STATE_RESET_WAIT) ||
                         (state_d != state_q);
      sw_q            <= i_Switches;
      sw_out_q        <= i_Switches & ~{4{chord_active}};
    end
  end

  // The animation only runs in INIT; any other mode parks it at step 0.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      anim_cnt  <= '0;
      anim_step <= 3'd0;
    end else if (state_q != STATE_INIT) begin
      anim_cnt  <= '0;
      anim_step <= 3'd0;
    end else if (anim_cnt == ANIM_LAST) begin
      anim_cnt  <= '0;
      anim_step <= (anim_step == STEP_LAST) ? 3'd0 : anim_step + 3'd1;
    end else begin
      anim_cnt  <= anim_cnt + TIMER_W'(1);
    end
  end

  assign o_State         = state_q;
  assign o_Counter_Reset = counter_reset_q;
  assign o_Segments_Anim = anim_segments(anim_step);
  assign o_Switches      = sw_out_q;

endmodule
